// File: rtl/int_arbiter_if.sv
// Controller-side bundle of the interrupt arbiter: register port plus request/ack/eoi handshake.
// master = MCU controller, slave = int_arbiter.
interface int_arbiter_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        int_ack;
  logic        eoi;
  logic        in_service;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
    input  cfg_rdata, int_req, int_vec, in_service
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
    output cfg_rdata, int_req, int_vec, in_service
  );
endinterface

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt controller: sync + edge-detect sources, latch pending, request the controller.
// Latency: source edge -> PEND in 3 edges, request 1 edge later; ack -> in_service in 1 edge.
// Backpressure: request held frozen until int_ack or software withdrawal; no nesting until eoi.
module int_arbiter #(
  parameter int          NUM_SRC  = 4,
  parameter logic [7:0]  VEC0     = 8'hF0,
  parameter logic [7:0]  VEC1     = 8'hAA,
  parameter logic [7:0]  VEC_BASE = 8'hB0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  int_arbiter_if.slave       bus
);

  localparam int IW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] pend, isr, en;
  logic               ge;
  logic [IW-1:0]      win_q, win;
  logic               any_cand;
  logic               int_req_q, in_service_q;
  logic [7:0]         int_vec_q;

  logic               wr_ctrl, wr_pend, wr_set;
  logic [NUM_SRC-1:0] rise, cand, ack_clr, pend_clr, pend_set, wdata_src;
  logic               ack_take, withdraw;
  logic               unused_wdata;

  function automatic logic [7:0] vec_of(input int i);
    if (i == 0)      return VEC0;
    else if (i == 1) return VEC1;
    else             return VEC_BASE + 8'(8 * (i - 2));
  endfunction

  assign wdata_src    = bus.cfg_wdata[NUM_SRC-1:0];
  assign unused_wdata = &{1'b0, bus.cfg_wdata[14:NUM_SRC]};
  assign wr_ctrl      = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_pend      = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign wr_set       = bus.cfg_we && (bus.cfg_addr == 2'd3);

  assign rise     = sync2 & ~sync3;
  assign ack_take = (state == REQ) && bus.int_ack;
  assign ack_clr  = ack_take ? (NUM_SRC'(1) << win_q) : '0;
  assign pend_clr = (wr_pend ? wdata_src : '0) | ack_clr;
  // Set terms are OR'd in after the clear so a coincident event is never lost.
  assign pend_set = rise | (wr_set ? wdata_src : '0);
  assign cand     = ge ? (pend & en) : '0;
  assign withdraw = !ge || !en[win_q] || !pend[win_q];

  always_comb begin
    win      = '0;
    any_cand = |cand;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      pend  <= '0;
      en    <= '0;
      ge    <= 1'b0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
      pend  <= (pend & ~pend_clr) | pend_set;
      if (wr_ctrl) begin
        ge <= bus.cfg_wdata[15];
        en <= wdata_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      win_q        <= '0;
      int_vec_q    <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      isr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            win_q     <= win;
            int_vec_q <= vec_of(int'(win));
            int_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            isr          <= NUM_SRC'(1) << win_q;
            in_service_q <= 1'b1;
            int_req_q    <= 1'b0;
            state        <= SERVICE;
          end else if (withdraw) begin
            int_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            isr          <= '0;
            in_service_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0: begin
        bus.cfg_rdata[15]          = ge;
        bus.cfg_rdata[NUM_SRC-1:0] = en;
      end
      2'd1:    bus.cfg_rdata[NUM_SRC-1:0] = pend;
      2'd2:    bus.cfg_rdata[NUM_SRC-1:0] = isr;
      default: bus.cfg_rdata = '0;
    endcase
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vec    = int_vec_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: per-cycle vector table plus hand sequences for corner cases.
module tb_int_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] irq;

  int_arbiter_if bus ();

  int_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic        eoi;
    logic        chk_o;
    logic        req;
    logic [7:0]  vec;
    logic        isv;
    logic [1:0]  raddr;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] i_irq, input logic we, input logic [1:0] addr,
                     input logic [15:0] wd, input logic ack, input logic e);
    @(negedge clk);
    irq           = i_irq;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wd;
    bus.int_ack   = ack;
    bus.eoi       = e;
    @(posedge clk);
    #1;
    bus.cfg_we  = 1'b0;
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
    bus.cfg_addr = a;
    #1;
    check(name, bus.cfg_rdata, exp);
  endtask

  task automatic chk_out(input string name, input logic req, input logic isv);
    check({name, " int_req"}, 16'(bus.int_req), 16'(req));
    check({name, " in_service"}, 16'(bus.in_service), 16'(isv));
  endtask

  task automatic do_reset();
    irq = 4'h0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    irq           = 4'h0;
    rst           = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 16'h0;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;

    //                irq  we addr wdata    ack eoi chk req vec    isv ra  rdata
    // single timer event
    tbl.push_back('{4'h0, 1, 0, 16'h8001, 0, 0, 1, 0, 8'h00, 0, 0, 16'h8001});
    tbl.push_back('{4'h1, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h1, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h1, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0001});
    tbl.push_back('{4'h1, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hF0, 0, 1, 16'h0001});
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 1, 16'h0000});
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 2, 16'h0001});
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 2, 16'h0000});
    // priority: sources 1 and 2 together, then source 2 after eoi
    tbl.push_back('{4'h0, 1, 0, 16'h800F, 0, 0, 1, 0, 8'h00, 0, 0, 16'h800F});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0006});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hAA, 0, 1, 16'h0006});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 1, 16'h0004});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 2, 16'h0000});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hB0, 0, 1, 16'h0004});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 2, 16'h0004});
    tbl.push_back('{4'h6, 0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 1, 16'h0000});
    // flush, then freeze: timer rises while source 1 is requested
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h0, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h2, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h2, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0000});
    tbl.push_back('{4'h2, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 1, 16'h0002});
    tbl.push_back('{4'h2, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hAA, 0, 1, 16'h0002});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hAA, 0, 1, 16'h0002});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hAA, 0, 1, 16'h0002});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hAA, 0, 1, 16'h0003});
    // withdrawal by W1C of the requested source, then timer is served
    tbl.push_back('{4'h3, 1, 1, 16'h0002, 0, 0, 0, 0, 8'h00, 0, 1, 16'h0001});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 2, 16'h0000});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hF0, 0, 1, 16'h0001});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 2, 16'h0001});
    tbl.push_back('{4'h3, 0, 0, 16'h0000, 0, 1, 1, 0, 8'h00, 0, 2, 16'h0000});

    // reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0);
    check("reset int_vec", 16'(bus.int_vec), 16'h0000);
    rd(2'd0, 16'h0000, "reset CTRL");
    rd(2'd1, 16'h0000, "reset PEND");
    rd(2'd2, 16'h0000, "reset ISR");
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].irq, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].eoi);
      bus.cfg_addr = tbl[i].raddr;
      #1;
      if (tbl[i].chk_o) begin
        chk_out($sformatf("row%0d", i), tbl[i].req, tbl[i].isv);
        if (tbl[i].req)
          check($sformatf("row%0d int_vec", i), 16'(bus.int_vec), 16'(tbl[i].vec));
      end
      check($sformatf("row%0d rdata", i), bus.cfg_rdata, tbl[i].rdata);
    end

    // masking by GE, then request on enable; withdraw + same-cycle ack -> ack wins
    do_reset();
    cyc(4'h0, 1, 2'd0, 16'h0003, 0, 0);
    cyc(4'h0, 0, 2'd0, 16'h0000, 1, 0);
    chk_out("spurious ack", 1'b0, 1'b0);
    rd(2'd2, 16'h0000, "spurious ack ISR");
    repeat (3) cyc(4'h2, 0, 2'd0, 16'h0000, 0, 0);
    rd(2'd1, 16'h0002, "masked PEND");
    cyc(4'h2, 0, 2'd0, 16'h0000, 0, 0);
    chk_out("masked", 1'b0, 1'b0);
    cyc(4'h2, 1, 2'd0, 16'h8003, 0, 0);
    chk_out("GE write edge", 1'b0, 1'b0);
    cyc(4'h2, 0, 2'd0, 16'h0000, 0, 0);
    chk_out("unmasked", 1'b1, 1'b0);
    check("unmasked int_vec", 16'(bus.int_vec), 16'h00AA);
    cyc(4'h2, 1, 2'd1, 16'h0002, 1, 0);
    chk_out("ack vs withdraw", 1'b0, 1'b1);
    rd(2'd2, 16'h0002, "ack vs withdraw ISR");
    rd(2'd1, 16'h0000, "ack vs withdraw PEND");
    cyc(4'h2, 0, 2'd0, 16'h0000, 0, 1);
    chk_out("eoi after ack", 1'b0, 1'b0);

    // set-wins on source 3: second edge lands on the ack edge; spurious eoi in REQ
    do_reset();
    cyc(4'h0, 1, 2'd0, 16'h8008, 0, 0);
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 0);
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 0);
    cyc(4'h0, 0, 2'd0, 16'h0000, 0, 0);
    rd(2'd1, 16'h0008, "src3 PEND");
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 0);
    chk_out("src3 req", 1'b1, 1'b0);
    check("src3 int_vec", 16'(bus.int_vec), 16'h00B8);
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 1);
    chk_out("spurious eoi", 1'b1, 1'b0);
    cyc(4'h8, 0, 2'd0, 16'h0000, 1, 0);
    chk_out("set-wins ack", 1'b0, 1'b1);
    rd(2'd2, 16'h0008, "set-wins ISR");
    rd(2'd1, 16'h0008, "set-wins PEND");
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 1);
    chk_out("set-wins eoi", 1'b0, 1'b0);
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 0);
    chk_out("re-request", 1'b1, 1'b0);
    check("re-request int_vec", 16'(bus.int_vec), 16'h00B8);
    cyc(4'h8, 0, 2'd0, 16'h0000, 1, 0);
    cyc(4'h8, 0, 2'd0, 16'h0000, 0, 1);
    cyc(4'h8, 1, 2'd3, 16'h0004, 0, 0);
    rd(2'd1, 16'h0004, "SWSET PEND");
    rd(2'd3, 16'h0000, "SWSET read");
    cyc(4'h8, 1, 2'd2, 16'hFFFF, 0, 0);
    rd(2'd2, 16'h0000, "ISR write ignored");
    chk_out("idle after swset", 1'b0, 1'b0);

    // asynchronous reset in SERVICE with a pending event
    do_reset();
    cyc(4'h0, 1, 2'd0, 16'h8001, 0, 0);
    repeat (3) cyc(4'h1, 0, 2'd0, 16'h0000, 0, 0);
    cyc(4'h1, 0, 2'd0, 16'h0000, 0, 0);
    chk_out("pre-reset req", 1'b1, 1'b0);
    cyc(4'h1, 0, 2'd0, 16'h0000, 1, 0);
    cyc(4'h1, 1, 2'd3, 16'h0002, 0, 0);
    chk_out("pre-reset service", 1'b0, 1'b1);
    rd(2'd1, 16'h0002, "pre-reset PEND");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 1'b0);
    check("async reset int_vec", 16'(bus.int_vec), 16'h0000);
    rd(2'd0, 16'h0000, "async reset CTRL");
    rd(2'd1, 16'h0000, "async reset PEND");
    rd(2'd2, 16'h0000, "async reset ISR");
    irq = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
